serial_adder: RTL

SERIAL_ADDER -- requirements
Module: serial_adder

---
 rtl/serial_adder_pkg.sv | 10 +
 rtl/fa_module.sv | 13 +
 rtl/serial_adder.sv | 98 +++++++++
 3 files changed

// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder: FSM state encoding.
package serial_adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/fa_module.sv
// One-bit full adder, the bit slice used by the serial adder.
module fa_module (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (ci & (a ^ b));

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder: one full-adder slice processes one operand bit per clock,
// LSB first, and publishes {cout_o, sum_o} on a single-cycle done_o pulse.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             cin_i,
    output logic [WIDTH-1:0] sum_o,
    output logic             cout_o,
    output logic             busy_o,
    output logic             done_o
);

    localparam int CW = $clog2(WIDTH + 1);

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    // Holds the sum bits already produced; the final bit is merged in on the last RUN edge.
    logic [WIDTH-2:0] sum_sr;
    logic [WIDTH-1:0] sum_shift;
    logic             carry;
    logic [CW-1:0]    count;
    logic             s_bit;
    logic             c_bit;
    logic             last;

    fa_module u_fa (
        .a  (a_sr[0]),
        .b  (b_sr[0]),
        .ci (carry),
        .s  (s_bit),
        .co (c_bit)
    );

    assign sum_shift = {s_bit, sum_sr};
    assign last      = (count == CW'(WIDTH - 1));
    assign busy_o    = (state != IDLE);
    assign done_o    = (state == DONE);

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (start_i) state_nxt = RUN;
            RUN:     if (last)    state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= IDLE;
            a_sr   <= '0;
            b_sr   <= '0;
            sum_sr <= '0;
            carry  <= 1'b0;
            count  <= '0;
            sum_o  <= '0;
            cout_o <= 1'b0;
        end else begin
            state <= state_nxt;
            unique case (state)
                IDLE: begin
                    if (start_i) begin
                        a_sr   <= a_i;
                        b_sr   <= b_i;
                        carry  <= cin_i;
                        sum_sr <= '0;
                        count  <= '0;
                    end
                end
                RUN: begin
                    a_sr   <= a_sr >> 1;
                    b_sr   <= b_sr >> 1;
                    sum_sr <= sum_shift[WIDTH-1:1];
                    carry  <= c_bit;
                    count  <= count + CW'(1);
                    // Results are published on the same edge that enters DONE.
                    if (last) begin
                        sum_o  <= sum_shift;
                        cout_o <= c_bit;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
